// File: rtl/operacion_math_pkg.sv
// Shared definitions for operacion_math_seq: operation codes and FSM states.
package operacion_math_pkg;

  localparam logic [1:0] OP_SUMA  = 2'b00;
  localparam logic [1:0] OP_RESTA = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    CALCULO = 2'b01,
    FIN     = 2'b10
  } estado_t;

endpackage

// File: rtl/div_restauracion.sv
// Restoring divider datapath: one quotient bit per step, MSB first.
// cociente/residuo present the values that the current step will produce,
// so the owner can capture the final result on the last step's edge.
module div_restauracion #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         carga,
  input  logic         paso,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] cociente,
  output logic [N-1:0] residuo
);

  logic [N-1:0] quo_r, rem_r, dsr_r;
  logic [N:0]   rem_shift, diff;
  logic         q_bit;

  // One restoring step: shift in the next dividend bit and try to subtract.
  // NOTE: every always_comb output gets a value on every path, so no latch can form.
  always_comb begin
    rem_shift = {rem_r, quo_r[N-1]};
    diff      = rem_shift - {1'b0, dsr_r};
    q_bit     = ~diff[N];
    residuo   = q_bit ? diff[N-1:0] : rem_shift[N-1:0];
    cociente  = {quo_r[N-2:0], q_bit};
  end

  // Operand load on accept, then one step per CALCULO cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_r <= '0;
      rem_r <= '0;
      dsr_r <= '0;
    end else if (carga) begin
      quo_r <= dividendo;
      rem_r <= '0;
      dsr_r <= divisor;
    end else if (paso) begin
      quo_r <= cociente;
      rem_r <= residuo;
    end
  end

endmodule

// File: rtl/operacion_math_seq.sv
// Sequential arithmetic unit: add/subtract in one cycle, shift-add multiply
// and restoring divide over N cycles. Division is built only when the macro
// OPERACION_MATH_DIV_EN is defined; otherwise Op=11 reports an error.
module operacion_math_seq
  import operacion_math_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   Num1,
  input  logic [N-1:0]   Num2,
  input  logic [1:0]     Op,
  input  logic           Inicio,
  output logic           Ocupado,
  output logic           Listo,
  output logic [2*N-1:0] Resultado,
  output logic [N-1:0]   Residuo,
  output logic           ErrorDiv
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  estado_t        estado;
  logic [CW-1:0]  cnt;
  logic           cnt_last;
  logic [1:0]     op_r;
  logic [N-1:0]   mcand, mplier;
  logic [2*N-1:0] prod_acc, prod_next;
  logic [N:0]     suma_ext, resta_ext;

  // Single-cycle results and the next partial product of the multiplier.
  always_comb begin
    suma_ext  = {1'b0, Num1} + {1'b0, Num2};
    resta_ext = {1'b0, Num1} - {1'b0, Num2};
    prod_next = prod_acc + (mplier[cnt] ? ({{N{1'b0}}, mcand} << cnt) : '0);
    cnt_last  = (cnt == CW'(N - 1));
  end

`ifdef OPERACION_MATH_DIV_EN
  logic         div_carga, div_paso;
  logic [N-1:0] div_coc, div_res;

  // Divider is loaded only for a non-zero divisor and stepped while calculating.
  always_comb begin
    div_carga = (estado == REPOSO) && Inicio && (Op == OP_DIV) && (Num2 != '0);
    div_paso  = (estado == CALCULO) && (op_r == OP_DIV);
  end

  div_restauracion #(.N(N)) u_div (
    .clk       (clk),
    .rst       (rst),
    .carga     (div_carga),
    .paso      (div_paso),
    .dividendo (Num1),
    .divisor   (Num2),
    .cociente  (div_coc),
    .residuo   (div_res)
  );
`endif

  // Control FSM with registered outputs; results only change on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= REPOSO;
      cnt       <= '0;
      op_r      <= OP_SUMA;
      mcand     <= '0;
      mplier    <= '0;
      prod_acc  <= '0;
      Ocupado   <= 1'b0;
      Listo     <= 1'b0;
      Resultado <= '0;
      Residuo   <= '0;
      ErrorDiv  <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          Listo <= 1'b0;
          if (Inicio) begin
            op_r     <= Op;
            mcand    <= Num1;
            mplier   <= Num2;
            prod_acc <= '0;
            cnt      <= '0;
            Ocupado  <= 1'b1;
            case (Op)
              OP_SUMA: begin
                Resultado <= {{(N-1){1'b0}}, suma_ext};
                Residuo   <= '0;
                ErrorDiv  <= 1'b0;
                Listo     <= 1'b1;
                estado    <= FIN;
              end
              OP_RESTA: begin
                Resultado <= {{(N-1){1'b0}}, resta_ext};
                Residuo   <= '0;
                ErrorDiv  <= 1'b0;
                Listo     <= 1'b1;
                estado    <= FIN;
              end
              OP_MULT: estado <= CALCULO;
              default: begin
`ifdef OPERACION_MATH_DIV_EN
                if (Num2 == '0) begin
                  Resultado <= '1;
                  Residuo   <= Num1;
                  ErrorDiv  <= 1'b1;
                  Listo     <= 1'b1;
                  estado    <= FIN;
                end else begin
                  estado <= CALCULO;
                end
`else
                Resultado <= '0;
                Residuo   <= '0;
                ErrorDiv  <= 1'b1;
                Listo     <= 1'b1;
                estado    <= FIN;
`endif
              end
            endcase
          end
        end
        CALCULO: begin
          if (op_r == OP_MULT) prod_acc <= prod_next;
          if (cnt_last) begin
            cnt      <= '0;
            ErrorDiv <= 1'b0;
            Listo    <= 1'b1;
            estado   <= FIN;
`ifdef OPERACION_MATH_DIV_EN
            if (op_r == OP_DIV) begin
              Resultado <= {{N{1'b0}}, div_coc};
              Residuo   <= div_res;
            end else
`endif
            begin
              Resultado <= prod_next;
              Residuo   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          Listo   <= 1'b0;
          Ocupado <= 1'b0;
          estado  <= REPOSO;
        end
        default: begin
          Listo   <= 1'b0;
          Ocupado <= 1'b0;
          estado  <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operacion_math_seq.sv
// Self-checking bench for operacion_math_seq (N=4). A cycle model computes the
// expected outputs from plain arithmetic; directed literals pin the model.
module tb_operacion_math_seq;
  import operacion_math_pkg::*;

  localparam int N = 4;

  logic           clk, rst;
  logic [N-1:0]   Num1, Num2;
  logic [1:0]     Op;
  logic           Inicio;
  logic           Ocupado, Listo, ErrorDiv;
  logic [2*N-1:0] Resultado;
  logic [N-1:0]   Residuo;

  int checks = 0;
  int errors = 0;

  operacion_math_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .Num1      (Num1),
    .Num2      (Num2),
    .Op        (Op),
    .Inicio    (Inicio),
    .Ocupado   (Ocupado),
    .Listo     (Listo),
    .Resultado (Resultado),
    .Residuo   (Residuo),
    .ErrorDiv  (ErrorDiv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted request completes after a fixed number of
  // edges beyond the accept edge (0 for single-cycle ops, N for iterative
  // ones); the expected values are plain arithmetic on the captured operands.
  logic           m_busy, m_listo, m_err, p_err;
  logic [2*N-1:0] m_res, p_res;
  logic [N-1:0]   m_rem, p_rem;
  int             m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_listo = 0; m_res = 0; m_rem = 0; m_err = 0; m_left = 0;
    end else if (m_listo) begin
      m_listo = 0;
      m_busy  = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_listo = 1; m_res = p_res; m_rem = p_rem; m_err = p_err;
      end
    end else if (Inicio) begin
      int a, b, d, lat;
      a = int'(Num1); b = int'(Num2);
      p_rem = 0; p_err = 0; lat = 0;
      case (Op)
        OP_SUMA:  p_res = 8'(a + b);
        OP_RESTA: begin
          d = a - b;
          p_res = 8'(((d + 16) % 16) + ((d < 0) ? 16 : 0));
        end
        OP_MULT: begin p_res = 8'(a * b); lat = N; end
        default: begin
`ifdef OPERACION_MATH_DIV_EN
          if (b == 0) begin
            p_res = 8'hFF; p_rem = 4'(a); p_err = 1;
          end else begin
            p_res = 8'(a / b); p_rem = 4'(a % b); lat = N;
          end
`else
          p_res = 0; p_err = 1;
`endif
        end
      endcase
      m_busy = 1;
      if (lat == 0) begin
        m_listo = 1; m_res = p_res; m_rem = p_rem; m_err = p_err;
      end else begin
        m_left = lat;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("ocupado", 32'(Ocupado), 32'(m_busy));
    check("listo", 32'(Listo), 32'(m_listo));
    check("resultado", 32'(Resultado), 32'(m_res));
    check("residuo", 32'(Residuo), 32'(m_rem));
    check("errordiv", 32'(ErrorDiv), 32'(m_err));
  end

  // Issue one request and return the number of edges after the accept edge
  // until Listo is seen. Optionally hold Inicio through FIN or pulse it mid-run.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op,
                        input bit hold_fin, input bit pulse_mid, output int edges);
    @(negedge clk);
    Num1 = a; Num2 = b; Op = op; Inicio = 1'b1;
    @(negedge clk);
    Inicio = hold_fin;
    edges = 0;
    while (Listo !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
      if (pulse_mid && edges == 1) begin
        Inicio = 1'b1; Num1 = 4'd1; Num2 = 4'd1; Op = OP_SUMA;
      end
      if (pulse_mid && edges == 2) begin
        Inicio = 1'b0; Num1 = a; Num2 = b; Op = op;
      end
    end
    check("listo_timeout", 32'(edges < 20), 32'd1);
  endtask

  initial begin
    int e;
    rst = 1'b1; Inicio = 1'b0; Num1 = '0; Num2 = '0; Op = OP_SUMA;
    repeat (2) @(negedge clk);
    check("rst_resultado", 32'(Resultado), 32'h0);
    check("rst_ocupado", 32'(Ocupado), 32'h0);
    check("rst_listo", 32'(Listo), 32'h0);
    #2 rst = 1'b0;

    // 9 + 12, Inicio held into FIN must be ignored
    run_op(4'd9, 4'd12, OP_SUMA, 1'b1, 1'b0, e);
    check("suma_lat", 32'(e), 32'd0);
    check("suma_res", 32'(Resultado), 32'h15);
    @(negedge clk);
    Inicio = 1'b0;
    check("suma_ocupado_after", 32'(Ocupado), 32'h0);
    check("suma_listo_after", 32'(Listo), 32'h0);

    // 15 + 15: carry into bit N
    run_op(4'd15, 4'd15, OP_SUMA, 1'b0, 1'b0, e);
    check("suma_max_res", 32'(Resultado), 32'h1E);

    // 3 - 5: wraps with borrow
    run_op(4'd3, 4'd5, OP_RESTA, 1'b0, 1'b0, e);
    check("resta_lat", 32'(e), 32'd0);
    check("resta_res", 32'(Resultado), 32'h1E);
    check("resta_err", 32'(ErrorDiv), 32'h0);

    // 9 - 2: no borrow
    run_op(4'd9, 4'd2, OP_RESTA, 1'b0, 1'b0, e);
    check("resta_nb_res", 32'(Resultado), 32'h07);

    // 15 * 15 with a stray Inicio mid-operation
    run_op(4'd15, 4'd15, OP_MULT, 1'b0, 1'b1, e);
    check("mult_lat", 32'(e), 32'd4);
    check("mult_res", 32'(Resultado), 32'hE1);
    check("mult_residuo", 32'(Residuo), 32'h0);

    // 3 * 5
    run_op(4'd3, 4'd5, OP_MULT, 1'b0, 1'b0, e);
    check("mult2_res", 32'(Resultado), 32'h0F);

`ifdef OPERACION_MATH_DIV_EN
    run_op(4'd13, 4'd4, OP_DIV, 1'b0, 1'b0, e);
    check("div_lat", 32'(e), 32'd4);
    check("div_res", 32'(Resultado), 32'h03);
    check("div_residuo", 32'(Residuo), 32'h1);
    check("div_err", 32'(ErrorDiv), 32'h0);

    run_op(4'd7, 4'd0, OP_DIV, 1'b0, 1'b0, e);
    check("div0_lat", 32'(e), 32'd0);
    check("div0_res", 32'(Resultado), 32'hFF);
    check("div0_residuo", 32'(Residuo), 32'h7);
    check("div0_err", 32'(ErrorDiv), 32'h1);
`else
    run_op(4'd13, 4'd4, OP_DIV, 1'b0, 1'b0, e);
    check("nodiv_lat", 32'(e), 32'd0);
    check("nodiv_res", 32'(Resultado), 32'h0);
    check("nodiv_residuo", 32'(Residuo), 32'h0);
    check("nodiv_err", 32'(ErrorDiv), 32'h1);
`endif

    // Reset in cycle 2 of a multiplication
    @(negedge clk);
    Num1 = 4'd7; Num2 = 4'd6; Op = OP_MULT; Inicio = 1'b1;
    @(negedge clk);
    Inicio = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_resultado", 32'(Resultado), 32'h0);
    check("abort_ocupado", 32'(Ocupado), 32'h0);
    check("abort_errordiv", 32'(ErrorDiv), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_listo", 32'(Listo), 32'h0);
    end
    #2 rst = 1'b0;
    Num1 = 4'd9; Num2 = 4'd12; Op = OP_SUMA; Inicio = 1'b1;
    @(negedge clk);
    Inicio = 1'b0;
    check("post_rst_listo", 32'(Listo), 32'h1);
    check("post_rst_res", 32'(Resultado), 32'h15);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operacion_math_seq.md
OPERACION_MATH_SEQ -- requirements
Module: operacion_math_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports Num1 and Num2, input, N bits each: unsigned operands.
REQ-005 The block SHALL have port Op, input, 2 bits: 00 suma, 01 resta, 10 multiplicacion, 11 division.
REQ-006 The block SHALL have port Inicio, input, 1 bit: start request.
REQ-007 The block SHALL have port Ocupado, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port Listo, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port Resultado, output, 2N bits: operation result.
REQ-010 The block SHALL have port Residuo, output, N bits: division remainder.
REQ-011 The block SHALL have port ErrorDiv, output, 1 bit: division by zero flag.

Function
REQ-012 The FSM SHALL have states REPOSO, CALCULO and FIN.
REQ-013 Inicio SHALL be accepted only in REPOSO; Num1, Num2 and Op SHALL be captured on the accept edge.
REQ-014 Inicio SHALL be ignored outside REPOSO, with no queuing.
REQ-015 Suma and resta SHALL go REPOSO->FIN directly: Listo high in the cycle after the accept edge (latency 1).
REQ-016 Suma SHALL be computed zero-extended to N+1 bits; Resultado[2N-1:N+1] SHALL be 0.
REQ-017 Resta SHALL place Num1-Num2 mod 2^N in Resultado[N-1:0] and the borrow (Num1<Num2) in Resultado[N], with upper bits 0.
REQ-018 Multiplicacion SHALL be iterative shift-add, one operand bit per cycle in CALCULO; full 2N-bit product; Listo rises N edges after accept.
REQ-019 Division SHALL be iterative restoring, one quotient bit per cycle; quotient in Resultado[N-1:0], upper bits 0; remainder in Residuo; Listo rises N edges after accept.
REQ-020 Division with Num2=0 SHALL go directly to FIN (latency 1) with Resultado all ones, Residuo=Num1 and ErrorDiv=1.
REQ-021 ErrorDiv SHALL be 0 for every other completion, and Residuo SHALL be 0 for non-division ops.
REQ-022 Ocupado SHALL be 1 in CALCULO and FIN and 0 in REPOSO.
REQ-023 FIN SHALL last exactly one cycle, then return to REPOSO; Inicio in FIN SHALL be ignored.
REQ-024 Resultado, Residuo and ErrorDiv SHALL hold their values from Listo until the next completion; intermediate iterations SHALL NOT be visible on them.
REQ-025 The iteration counter SHALL run 0..N-1 and SHALL NOT wrap into a further operation.

Reset
REQ-026 While rst is high the block SHALL be in REPOSO with Ocupado=0, Listo=0, Resultado=0, Residuo=0, ErrorDiv=0 and the counter at 0.
REQ-027 rst asserted mid-operation SHALL abort the operation immediately, with no Listo pulse.
REQ-028 Inicio SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro OPERACION_MATH_DIV_EN SHALL control division.
REQ-030 With OPERACION_MATH_DIV_EN defined, division SHALL behave as REQ-019/020.
REQ-031 With OPERACION_MATH_DIV_EN undefined, no divider logic SHALL exist; Op=11 SHALL complete with latency 1, Resultado=0, Residuo=0 and ErrorDiv=1.

Structure
REQ-032 Package operacion_math_pkg SHALL hold the Op code constants (OP_SUMA, OP_RESTA, OP_MULT, OP_DIV) and the FSM state typedef.
REQ-033 The restoring divider datapath SHALL be sub-module div_restauracion (parameter N), instantiated only under OPERACION_MATH_DIV_EN.
REQ-034 The multiplier and FSM SHALL reside in operacion_math_seq.

Verification (N=4, macro defined unless stated)
REQ-035 Bench SHALL drive Op=00, 9+12, then check Listo after 1 edge with Resultado=0x15 and Ocupado=0 in the following cycle.
REQ-036 Bench SHALL drive Op=01, 3-5, then check Resultado=0x1E (low nibble E, borrow=1) and ErrorDiv=0.
REQ-037 Bench SHALL drive Op=10, 15*15, then check Listo exactly 4 edges after accept with Resultado=0xE1; Inicio pulsed mid-operation SHALL be ignored.
REQ-038 Bench SHALL drive Op=11, 13/4, then check Listo after 4 edges with Resultado=0x03 and Residuo=1; then 7/0 SHALL give Listo after 1 edge, Resultado=0xFF, Residuo=7 and ErrorDiv=1.
REQ-039 Bench SHALL assert rst at cycle 2 of a multiplication, then check that no Listo occurs, all outputs are 0, and a new suma is accepted on the first edge after release.
REQ-040 Bench SHALL build with the macro undefined, drive Op=11 13/4, then check latency 1, Resultado=0 and ErrorDiv=1.
